// File: rtl/flp_to_fx_out_buffer_if.sv
// Sample stream between the float estimator and the PCM consumer.
// in/in_valid is a stall-free strobe; out/out_valid/out_ready is a ready/valid handshake.
interface flp_to_fx_out_buffer_if #(
  parameter int n_exp  = 8,
  parameter int n_mant = 23,
  parameter int OUT_W  = 16
);
  // in is taken on every cycle in_valid is high (there is no ready on that side).
  // A sample on out moves on a rising edge where out_valid && out_ready. While
  // out_valid is high and out_ready is low, out must not change.
  logic [n_exp+n_mant:0] in;
  logic                  in_valid;
  logic [OUT_W-1:0]      out;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output in, in_valid, out_ready, input out, out_valid);
  modport slave  (input in, in_valid, out_ready, output out, out_valid);
endinterface

// File: rtl/flp_to_fx_out_buffer.sv
// Float estimate -> signed Q1.(OUT_W-1) PCM, 2-stage pipeline into a FIFO with sticky flags.
// Defining FLP2FX_STATS_EN adds the sat_cnt clipped-sample counter port.
module flp_to_fx_out_buffer #(
  parameter int n_exp      = 8,
  parameter int n_mant     = 23,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  flp_to_fx_out_buffer_if.slave  bus,
  output logic                   sat,
  output logic                   overrun,
  input  logic                   clr_flags
`ifdef FLP2FX_STATS_EN
  ,
  output logic [15:0]            sat_cnt
`endif
);
  localparam int BIAS = 2 ** (n_exp - 1) - 1;
  localparam int MW   = n_mant + OUT_W + 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [MW:0]      NEG_LIM = (MW + 1)'(1) << (OUT_W - 1);
  localparam logic [MW:0]      POS_LIM = NEG_LIM - (MW + 1)'(1);
  localparam logic [OUT_W-1:0] PCM_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] PCM_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  logic                sign_c;
  logic [n_exp-1:0]    exp_c;
  logic [n_mant-1:0]   man_c;
  assign {sign_c, exp_c, man_c} = bus.in;

  logic                s1_valid, s1_sign, s1_zero, s1_nan, s1_ovf;
  logic [n_mant:0]     s1_sig;
  logic signed [31:0]  s1_sh;

  // Any magnitude >= 2.0 clips for either sign, so it is folded in with Inf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_sig   <= '0;
      s1_sh    <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= sign_c;
        s1_sig  <= {1'b1, man_c};
        s1_sh   <= int'(exp_c) - BIAS + OUT_W - 1 - n_mant;
        s1_zero <= (exp_c == '0);
        s1_nan  <= (&exp_c) && (|man_c);
        s1_ovf  <= ((&exp_c) && (man_c == '0)) || (int'(exp_c) > BIAS);
      end
    end
  end

  // val2 carries one extra fraction bit so half-up rounding is a +1 then >>1.
  logic signed [31:0] ls;
  logic [MW-1:0]      val2;
  logic [MW:0]        mag;
  logic [OUT_W-1:0]   res;
  logic               clip;

  always_comb begin
    ls   = s1_sh + 32'sd1;
    val2 = '0;
    res  = '0;
    clip = 1'b0;
    if (ls >= 0)
      val2 = MW'(s1_sig) << ls;
    else if (-ls < MW)
      val2 = MW'(s1_sig) >> (-ls);
    mag = ({1'b0, val2} + (MW + 1)'(1)) >> 1;
    if (s1_nan || s1_zero) begin
      res = '0;
    end else if (s1_ovf) begin
      clip = 1'b1;
      res  = s1_sign ? PCM_MIN : PCM_MAX;
    end else if (s1_sign) begin
      if (mag > NEG_LIM) begin
        clip = 1'b1;
        res  = PCM_MIN;
      end else begin
        res = OUT_W'(-mag);
      end
    end else if (mag > POS_LIM) begin
      clip = 1'b1;
      res  = PCM_MAX;
    end else begin
      res = OUT_W'(mag);
    end
  end

  logic             s2_valid, s2_clip;
  logic [OUT_W-1:0] s2_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_clip  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= res;
        s2_clip <= clip;
      end
    end
  end

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [OUT_W-1:0] last;
  logic             empty, full, rd_en, wr_en, clip_ev, drop_ev;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign rd_en   = !empty && bus.out_ready;
  assign wr_en   = s2_valid && (!full || rd_en);
  assign clip_ev = s2_valid && s2_clip;
  assign drop_ev = s2_valid && full && !rd_en;

  assign bus.out_valid = !empty;
  assign bus.out       = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (!wr_en && rd_en) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else if (clr_flags) begin
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clip_ev) sat     <= 1'b1;
      if (drop_ev) overrun <= 1'b1;
    end
  end

`ifdef FLP2FX_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sat_cnt <= '0;
    else if (clr_flags)
      sat_cnt <= '0;
    else if (clip_ev && (sat_cnt != 16'hFFFF))
      sat_cnt <= sat_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_flp_to_fx_out_buffer.sv
// Directed bench for flp_to_fx_out_buffer: hand-computed float->PCM vectors, flags, FIFO overrun.
module tb_flp_to_fx_out_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sat, overrun;
  logic        clr_flags = 1'b0;
`ifdef FLP2FX_STATS_EN
  logic [15:0] sat_cnt;
`endif

  flp_to_fx_out_buffer_if #(.n_exp(8), .n_mant(23), .OUT_W(16)) bus ();

  flp_to_fx_out_buffer #(.n_exp(8), .n_mant(23), .OUT_W(16), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat       (sat),
    .overrun   (overrun),
    .clr_flags (clr_flags)
`ifdef FLP2FX_STATS_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds in_valid across exactly one rising edge.
  task automatic push(input logic [31:0] word);
    bus.in       = word;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] word, input logic [15:0] pcm);
    push(word);
    exp_q.push_back(pcm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Compares the head before the edge that pops it; bounded by a cycle budget.
  task automatic drain();
    int guard = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 200) begin
      if (bus.out_valid) check("data", 32'(bus.out), 32'(exp_q.pop_front()));
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  // Float encoding of n * 2^-15, i.e. the value whose PCM code is n.
  function automatic logic [31:0] pcm_float(input int n);
    int p = 0;
    for (int i = 0; i < 16; i++) if ((n >> i) & 1) p = i;
    return {1'b0, 8'(127 + p - 15), 23'((n << (23 - p)) & 32'h7FFFFF)};
  endfunction

  initial begin
    bus.in        = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    idle(2);
    check("rst_out", 32'(bus.out), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_sat", 32'(sat), 0);
    check("rst_overrun", 32'(overrun), 0);
`ifdef FLP2FX_STATS_EN
    check("rst_sat_cnt", 32'(sat_cnt), 0);
`endif
    rst = 1'b1;
    idle(2);

    // Latency: capture edge, S2 edge, FIFO write edge.
    bus.out_ready = 1'b1;
    push(32'h3F000000);
    check("lat_e1", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("lat_e2", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("lat_e3_valid", 32'(bus.out_valid), 1);
    check("lat_e3_data", 32'(bus.out), 32'h4000);
    @(negedge clk);
    check("pop_empty", 32'(bus.out_valid), 0);
    check("hold_last", 32'(bus.out), 32'h4000);
    check("half_sat", 32'(sat), 0);
    bus.out_ready = 1'b0;

    // Non-clipping vectors, back to back.
    push_exp(32'hBF800000, 16'h8000);
    push_exp(32'h7FC00000, 16'h0000);
    push_exp(32'h00000001, 16'h0000);
    push_exp(32'h38000000, 16'h0001);
    push_exp(32'h37800000, 16'h0001);
    push_exp(32'h37000000, 16'h0000);
    push_exp(32'h3F400000, 16'h6000);
    push_exp(32'hBF000000, 16'hC000);
    push_exp(32'hB8000000, 16'hFFFF);
    idle(3);
    drain();
    check("plain_sat", 32'(sat), 0);
    check("plain_overrun", 32'(overrun), 0);

    // Clipping vectors.
    push_exp(32'h3F800000, 16'h7FFF);
    push_exp(32'h7F800000, 16'h7FFF);
    idle(3);
    drain();
    check("clip_sat", 32'(sat), 1);
`ifdef FLP2FX_STATS_EN
    check("clip_cnt2", 32'(sat_cnt), 2);
`endif
    push_exp(32'h3F7FFFFF, 16'h7FFF);
    push_exp(32'hFF800000, 16'h8000);
    push_exp(32'hC0000000, 16'h8000);
    idle(3);
    drain();
`ifdef FLP2FX_STATS_EN
    check("clip_cnt5", 32'(sat_cnt), 5);
`endif
    clear_flags();
    check("clr_sat", 32'(sat), 0);
`ifdef FLP2FX_STATS_EN
    check("clr_cnt", 32'(sat_cnt), 0);
`endif

    // Overrun: 18 strobes into a 16-deep FIFO with the consumer stalled.
    for (int n = 1; n <= 18; n++) begin
      push(pcm_float(n));
      if (n <= 16) exp_q.push_back(16'(n));
    end
    idle(3);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      check("ovr_hold", 32'(bus.out), 1);
      @(negedge clk);
    end
    drain();
    check("ovr_empty", 32'(bus.out_valid), 0);
    check("ovr_last", 32'(bus.out), 16);
    check("ovr_sat", 32'(sat), 0);
    clear_flags();
    check("clr_overrun", 32'(overrun), 0);

    // Reset with samples in flight: nothing may emerge afterwards.
    push(pcm_float(5));
    push(pcm_float(6));
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(5);
    check("post_rst_valid", 32'(bus.out_valid), 0);
    check("post_rst_out", 32'(bus.out), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
